// File: rtl/row_merge_engine_if.sv
// Tile stream bundle for row_merge_engine.
// Master drives input tiles and output ready; slave is the engine.
interface row_merge_engine_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_LEN    = 4
);
  localparam int CW = $clog2(ROW_LEN + 1);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_value;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_value;
  logic                  out_last;
  logic                  row_done;
  logic                  moved;
  logic [CW-1:0]         merge_count;

  modport master (
    output in_valid, in_value, out_ready,
    input  in_ready, out_valid, out_value,
    input  out_last, row_done, moved, merge_count
  );

  modport slave (
    input  in_valid, in_value, out_ready,
    output in_ready, out_valid, out_value,
    output out_last, row_done, moved, merge_count
  );
endinterface

// File: rtl/row_merge_engine.sv
// Streaming 2048 left-slide/merge of one row of tile exponents.
// Define ROW_MERGE_STATS_EN to compute the moved/merge_count stats.
module row_merge_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_LEN    = 4
) (
  input logic            clk,
  input logic            rst,
  row_merge_engine_if.slave bus
);
  localparam int CW = $clog2(ROW_LEN + 1);
  localparam logic [1:0] LOAD  = 2'd0;
  localparam logic [1:0] FLUSH = 2'd1;
  localparam logic [1:0] PAD   = 2'd2;
  localparam logic [CW-1:0] LAST = CW'(ROW_LEN - 1);
  localparam logic [CW-1:0] FULL = CW'(ROW_LEN);
  localparam logic [DATA_WIDTH-1:0] MAXV = '1;

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] pend;
  logic                  pend_v;
  logic [CW-1:0]         in_cnt;
  logic [CW-1:0]         out_cnt;
  logic                  out_valid;
  logic                  out_last;
  logic                  row_done;
  logic [DATA_WIDTH-1:0] out_value;

  logic                  slot_free;
  logic                  in_ready;
  logic                  acc;
  logic                  out_hs;
  logic                  do_load;
  logic                  do_merge;
  logic                  do_swap;
  logic                  do_flush;
  logic                  do_pad;
  logic                  row_end;
  logic                  emit;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] emit_val;

  always_comb begin
    slot_free = !out_valid || bus.out_ready;
    in_ready  = (state == LOAD) && slot_free;
    acc       = bus.in_valid && in_ready;
    out_hs    = out_valid && bus.out_ready;
    do_load   = acc && (bus.in_value != '0) && !pend_v;
    do_merge  = acc && (bus.in_value != '0) && pend_v
                && (pend == bus.in_value);
    do_swap   = acc && (bus.in_value != '0) && pend_v
                && (pend != bus.in_value);
    do_flush  = (state == FLUSH) && pend_v && slot_free;
    do_pad    = (state == PAD) && slot_free && (out_cnt != FULL);
    row_end   = (state == PAD) && out_hs && out_last;
    emit      = do_merge || do_swap || do_flush || do_pad;
    merged    = (pend == MAXV) ? MAXV : pend + DATA_WIDTH'(1);
    emit_val  = pend;
    if (do_merge) emit_val = merged;
    else if (do_pad) emit_val = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      pend      <= '0;
      pend_v    <= 1'b0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      out_valid <= 1'b0;
      out_value <= '0;
      out_last  <= 1'b0;
      row_done  <= 1'b0;
    end else begin
      row_done <= row_end;
      if (emit) begin
        out_valid <= 1'b1;
        out_value <= emit_val;
        out_last  <= (out_cnt == LAST);
        out_cnt   <= out_cnt + CW'(1);
      end else if (out_hs) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (do_load || do_swap) begin
        pend   <= bus.in_value;
        pend_v <= 1'b1;
      end else if (do_merge || do_flush) begin
        pend_v <= 1'b0;
      end
      if (acc) begin
        in_cnt <= in_cnt + CW'(1);
        if (in_cnt == LAST) state <= FLUSH;
      end
      if (state == FLUSH && (!pend_v || slot_free))
        state <= PAD;
      if (row_end) begin
        state   <= LOAD;
        pend_v  <= 1'b0;
        in_cnt  <= '0;
        out_cnt <= '0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_value = out_value;
  assign bus.out_last  = out_last;
  assign bus.row_done  = row_done;

`ifdef ROW_MERGE_STATS_EN
  logic [CW-1:0] pend_idx;
  logic [CW-1:0] merge_count;
  logic          moved;

  // A tile has moved when it leaves from a different slot than it entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_idx    <= '0;
      merge_count <= '0;
      moved       <= 1'b0;
    end else begin
      if (do_load || do_swap) pend_idx <= in_cnt;
      if (acc && in_cnt == '0) begin
        merge_count <= '0;
        moved       <= 1'b0;
      end else if (do_merge) begin
        merge_count <= merge_count + CW'(1);
        moved       <= 1'b1;
      end else if ((do_swap || do_flush) && pend_idx != out_cnt) begin
        moved <= 1'b1;
      end
    end
  end

  assign bus.moved       = moved;
  assign bus.merge_count = merge_count;
`else
  assign bus.moved       = 1'b0;
  assign bus.merge_count = '0;
`endif
endmodule

// File: tb/tb_row_merge_engine.sv
// Bench for row_merge_engine: directed table, corner sequences,
// and random rows against a list-based slide/merge model.
module tb_row_merge_engine;
  typedef logic [3:0][7:0] row_t;
  typedef struct packed {
    row_t       row;
    row_t       exp;
    logic [2:0] mc;
    logic       mv;
    logic       hold3;
  } vec_t;

`ifdef ROW_MERGE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  row_merge_engine_if #(.DATA_WIDTH(8), .ROW_LEN(4)) bus ();

  row_merge_engine #(.DATA_WIDTH(8), .ROW_LEN(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic row_t mk(input int a, b, c, d);
    row_t r;
    r[0] = 8'(a);
    r[1] = 8'(b);
    r[2] = 8'(c);
    r[3] = 8'(d);
    return r;
  endfunction

  function automatic vec_t mkv(input row_t r, input row_t e,
                               input int mc, input bit mv,
                               input bit h);
    vec_t v;
    v.row   = r;
    v.exp   = e;
    v.mc    = 3'(mc);
    v.mv    = mv;
    v.hold3 = h;
    return v;
  endfunction

  // Compact nonzero tiles, merge equal neighbours pairwise, pad with 0.
  function automatic void model(input row_t r, output row_t o,
                                output int mc, output bit mv);
    logic [7:0] q[$];
    int k;
    int i;
    o  = '0;
    mc = 0;
    k  = 0;
    for (int j = 0; j < 4; j++)
      if (r[j] != 0) q.push_back(r[j]);
    i = 0;
    while (i < q.size()) begin
      if (i + 1 < q.size() && q[i] == q[i+1]) begin
        o[k] = (q[i] == 8'd255) ? 8'd255 : q[i] + 8'd1;
        mc++;
        i += 2;
      end else begin
        o[k] = q[i];
        i++;
      end
      k++;
    end
    mv = (o != r);
  endfunction

  task automatic run_row(input row_t r, input row_t e, input int emc,
                         input bit emv, input int stall_pct,
                         input bit hold3, input string nm);
    int ni;
    int no;
    int cyc;
    int stalls;
    bit held;
    bit done;
    logic [7:0] hv;
    row_t got;
    ni = 0; no = 0; cyc = 0; stalls = 0;
    held = 0; done = 0; hv = 0; got = '0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (held) chk({nm, "_hold_value"}, bus.out_value, hv);
      bus.in_valid = (ni < 4) && ($urandom_range(0, 99) >= stall_pct);
      bus.in_value = (ni < 4) ? r[ni] : 8'd0;
      if (hold3 && bus.out_valid && stalls < 3) begin
        bus.out_ready = 1'b0;
        stalls++;
      end else begin
        bus.out_ready = ($urandom_range(0, 99) >= stall_pct);
      end
      #1;
      held = bus.out_valid && !bus.out_ready;
      if (held) begin
        hv = bus.out_value;
        chk({nm, "_stall_in_ready"}, bus.in_ready, 0);
      end
      if (bus.in_valid && bus.in_ready) ni++;
      if (bus.out_valid && bus.out_ready) begin
        got[no] = bus.out_value;
        chk({nm, "_out_last"}, bus.out_last, (no == 3));
        no++;
        if (no == 4) done = 1;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout outputs=%0d required=4", nm, no);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    chk({nm, "_row_done"}, bus.row_done, 1);
    chk({nm, "_merge_count"}, bus.merge_count, STATS ? emc : 0);
    chk({nm, "_moved"}, bus.moved, STATS ? emv : 0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_tile%0d", nm, i), got[i], e[i]);
    @(negedge clk);
    #1;
    chk({nm, "_row_done_pulse"}, bus.row_done, 0);
  endtask

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    row_t r;
    row_t e;
    int mc;
    bit mv;
    checks = 0;
    failures = 0;
    vecs[0] = mkv(mk(1,1,2,0), mk(2,2,0,0), 1, 1, 0);
    vecs[1] = mkv(mk(1,1,1,1), mk(2,2,0,0), 2, 1, 0);
    vecs[2] = mkv(mk(1,2,3,4), mk(1,2,3,4), 0, 0, 0);
    vecs[3] = mkv(mk(0,0,0,3), mk(3,0,0,0), 0, 1, 0);
    vecs[4] = mkv(mk(255,255,0,0), mk(255,0,0,0), 1, 1, 0);
    vecs[5] = mkv(mk(2,0,2,2), mk(3,2,0,0), 1, 1, 1);
    vecs[6] = mkv(mk(0,5,5,5), mk(6,5,0,0), 1, 1, 0);

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_value = 8'd0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_value", bus.out_value, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_row_done", bus.row_done, 0);
    chk("rst_moved", bus.moved, 0);
    chk("rst_merge_count", bus.merge_count, 0);

    for (int i = 0; i < 7; i++)
      run_row(vecs[i].row, vecs[i].exp, int'(vecs[i].mc), vecs[i].mv,
              0, vecs[i].hold3, $sformatf("vec%0d", i));

    // Reset in the middle of a row.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_value = 8'd1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("midrow_out_valid", bus.out_valid, 1);
    chk("midrow_out_value", bus.out_value, 2);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_out_value", bus.out_value, 0);
    chk("midrst_out_last", bus.out_last, 0);
    chk("midrst_row_done", bus.row_done, 0);
    chk("midrst_moved", bus.moved, 0);
    chk("midrst_merge_count", bus.merge_count, 0);
    run_row(mk(0,0,0,0), mk(0,0,0,0), 0, 0, 0, 0, "zeros");

    for (int n = 0; n < 40; n++) begin
      for (int j = 0; j < 4; j++) begin
        case ($urandom_range(0, 9))
          0: r[j] = 8'd255;
          1: r[j] = 8'd254;
          default: r[j] = 8'($urandom_range(0, 3));
        endcase
      end
      model(r, e, mc, mv);
      run_row(r, e, mc, mv, $urandom_range(0, 40), 0,
              $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
